// File: rtl/fifo_read_streamer.sv
// ============================================================================
// Module   : fifo_read_streamer
// Brief    : Pops a fixed-latency FIFO, buffers returning words, presents them
//            as a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_streamer #(
  parameter int WIDTH             = 8,
  parameter int READ_DATA_LATENCY = 2,
  parameter int BUF_DEPTH         = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fifo_may_pop,
  output logic                           fifo_pop,
  input  logic [WIDTH-1:0]               fifo_pop_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam int SW = CW + 1;
  localparam int L  = READ_DATA_LATENCY;
  localparam logic [PW-1:0] c_LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] c_DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [SW-1:0] c_DEPTH_S  = SW'(BUF_DEPTH);

  logic [L-1:0]     r_s;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [WIDTH-1:0] r_out_data;

  logic [SW-1:0]    w_inflight;
  logic [L-1:0]     w_s_next;
  logic             w_pop;
  logic             w_arrive;
  logic             w_xfer;
  logic [PW-1:0]    w_rd_next;
  logic [PW-1:0]    w_wr_next;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] w_head;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < L; i++) begin
      w_inflight = w_inflight + SW'(r_s[i]);
    end
  end

  // Pop decision uses registered state only, never out_ready.
  assign w_pop    = !rst && fifo_may_pop && ((SW'(r_count) + w_inflight) < c_DEPTH_S);
  assign fifo_pop = w_pop;

  generate
    if (L == 1) begin : g_lat1
      assign w_s_next = w_pop;
    end else begin : g_latn
      assign w_s_next = {r_s[L-2:0], w_pop};
    end
  endgenerate

  assign w_arrive  = r_s[L-1];
  assign w_xfer    = (r_count != '0) && out_ready;
  assign w_rd_next = w_xfer   ? f_inc(r_rd_ptr) : r_rd_ptr;
  assign w_wr_next = w_arrive ? f_inc(r_wr_ptr) : r_wr_ptr;

  always_comb begin
    w_count_next = r_count;
    if (w_arrive && !w_xfer) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_arrive && w_xfer) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // A word landing in the next head slot is only possible when it becomes the head.
  assign w_head = (w_arrive && (r_wr_ptr == w_rd_next)) ? fifo_pop_data : r_buf[w_rd_next];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s        <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_out_data <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      assert (!(w_arrive && (r_count == c_DEPTH_C) && !w_xfer))
        else $error("fifo_read_streamer: buffer overflow");
      r_s      <= w_s_next;
      r_count  <= w_count_next;
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      if (w_arrive) begin
        r_buf[r_wr_ptr] <= fifo_pop_data;
      end
      if (w_count_next != '0) begin
        r_out_data <= w_head;
      end
    end
  end

  assign out_valid = (r_count != '0) && !rst;
  assign out_data  = r_out_data;
  assign occupancy = r_count;

endmodule

`default_nettype wire
